axis_fifo_arbiter: RTL and testbench

// Round-robin burst arbiter sharing one axis_fifo write port among NUM_PORTS AXI-Stream sources.

---
 rtl/axis_fifo_arbiter.sv | 175 +++++++++++++++++
 tb/tb_axis_fifo_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_arbiter.sv
// axis_fifo_arbiter
// Round-robin burst arbiter that shares one axis_fifo write port among
// NUM_PORTS AXI-Stream sources. A source is granted for a burst of at most
// BURST_LEN beats, and only when the FIFO has room for a full burst. Each beat
// carries the source index on tid, and tlast marks a full-length burst end.
module axis_fifo_arbiter #(
  parameter int  AXIS_TDATA_WIDTH = 32,
  parameter int  NUM_PORTS        = 4,
  parameter int  BURST_LEN        = 16,
  parameter int  FIFO_DEPTH       = 512,
  parameter int  IDLE_TIMEOUT     = 8,
  parameter int  HOLD_CYCLES      = 2,
  localparam int ID_WIDTH         = $clog2(NUM_PORTS)
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  input  logic [15:0]                           write_count,
  input  logic [NUM_PORTS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]                  s_axis_tvalid,
  output logic [NUM_PORTS-1:0]                  s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic [ID_WIDTH-1:0]                   m_axis_tid,
  output logic                                  m_axis_tlast,
  output logic                                  busy
);

  localparam int                BEAT_W    = $clog2(BURST_LEN + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [7:0]        IDLE_LAST = 8'(IDLE_TIMEOUT - 1);
  localparam logic [3:0]        HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [16:0]       DEPTH_17  = 17'(FIFO_DEPTH);
  localparam logic [16:0]       BURST_17  = 17'(BURST_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t                      state_r;
  logic [ID_WIDTH-1:0]         grant_r;
  logic [ID_WIDTH-1:0]         rr_ptr_r;
  logic [BEAT_W-1:0]           beat_cnt_r;
  logic [7:0]                  idle_cnt_r;
  logic [3:0]                  hold_cnt_r;
  logic                        tlast_r;
  logic                        busy_r;

  logic [16:0]                 wc_17_s;
  logic [16:0]                 free_17_s;
  logic                        room_s;
  logic                        pick_found_s;
  logic [ID_WIDTH-1:0]         pick_idx_s;
  int                          cand_v;
  logic [AXIS_TDATA_WIDTH-1:0] sel_data_s;
  logic                        sel_valid_s;
  logic                        in_burst_s;
  logic                        hs_s;

  // FIFO room check: a full burst must fit; an out-of-range count means no room
  always_comb begin
    wc_17_s   = {1'b0, write_count};
    free_17_s = DEPTH_17 - wc_17_s;
    if (wc_17_s > DEPTH_17) begin
      room_s = 1'b0;
    end else begin
      room_s = (free_17_s >= BURST_17);
    end
  end

  // Round-robin search: first valid port after rr_ptr_r; nearest candidate wins
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = {ID_WIDTH{1'b0}};
    cand_v       = 0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand_v = int'(rr_ptr_r) + k;
      cand_v = (cand_v >= NUM_PORTS) ? (cand_v - NUM_PORTS) : cand_v;
      for (int j = 0; j < NUM_PORTS; j++) begin
        pick_found_s = (cand_v == j && s_axis_tvalid[j]) ? 1'b1 : pick_found_s;
        pick_idx_s   = (cand_v == j && s_axis_tvalid[j]) ? ID_WIDTH'(j) : pick_idx_s;
      end
    end
  end

  // Source mux driven by the registered grant
  always_comb begin
    sel_data_s  = {AXIS_TDATA_WIDTH{1'b0}};
    sel_valid_s = 1'b0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      sel_data_s  = (grant_r == ID_WIDTH'(j)) ?
                    s_axis_tdata[j*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH] : sel_data_s;
      sel_valid_s = (grant_r == ID_WIDTH'(j)) ? s_axis_tvalid[j] : sel_valid_s;
    end
  end

  // Pass-through handshake: only tvalid->tvalid and tready->tready paths exist
  always_comb begin
    in_burst_s    = (state_r == ST_BURST);
    m_axis_tdata  = sel_data_s;
    m_axis_tvalid = in_burst_s & sel_valid_s;
    hs_s          = in_burst_s & sel_valid_s & m_axis_tready;
    s_axis_tready = {NUM_PORTS{1'b0}};
    for (int j = 0; j < NUM_PORTS; j++) begin
      s_axis_tready[j] = in_burst_s & m_axis_tready & (grant_r == ID_WIDTH'(j));
    end
  end

  assign m_axis_tid   = grant_r;
  assign m_axis_tlast = tlast_r;
  assign busy         = busy_r;

  // Arbitration FSM: grant in IDLE, count beats/idle cycles in BURST, settle in HOLD
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r    <= ST_IDLE;
      grant_r    <= {ID_WIDTH{1'b0}};
      rr_ptr_r   <= ID_WIDTH'(NUM_PORTS - 1);
      beat_cnt_r <= {BEAT_W{1'b0}};
      idle_cnt_r <= 8'd0;
      hold_cnt_r <= 4'd0;
      tlast_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (room_s && pick_found_s) begin
            state_r    <= ST_BURST;
            grant_r    <= pick_idx_s;
            beat_cnt_r <= {BEAT_W{1'b0}};
            idle_cnt_r <= 8'd0;
            tlast_r    <= (BEAT_LAST == {BEAT_W{1'b0}});
            busy_r     <= 1'b1;
          end
        end
        ST_BURST: begin
          if ((hs_s && beat_cnt_r == BEAT_LAST) ||
              (!sel_valid_s && idle_cnt_r == IDLE_LAST)) begin
            // Full burst handed over, or source went quiet too long
            state_r    <= ST_HOLD;
            rr_ptr_r   <= grant_r;
            beat_cnt_r <= {BEAT_W{1'b0}};
            idle_cnt_r <= 8'd0;
            hold_cnt_r <= 4'd0;
            tlast_r    <= 1'b0;
          end else if (hs_s) begin
            beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
            idle_cnt_r <= 8'd0;
            tlast_r    <= ((beat_cnt_r + BEAT_W'(1)) == BEAT_LAST);
          end else if (!sel_valid_s) begin
            idle_cnt_r <= idle_cnt_r + 8'd1;
          end else begin
            idle_cnt_r <= 8'd0;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_r == HOLD_LAST) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            hold_cnt_r <= hold_cnt_r + 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tlast_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_fifo_arbiter.sv
// Testbench for axis_fifo_arbiter: directed scenarios followed by a random
// phase, every cycle compared against a transaction-level reference model.
module tb_axis_fifo_arbiter;

  localparam int W = 32, N = 4, BL = 16, DEPTH = 512, TO = 8, HC = 2;

  logic           aclk = 1'b0;
  logic           areset;
  logic [15:0]    write_count;
  logic [N*W-1:0] s_axis_tdata;
  logic [N-1:0]   s_axis_tvalid;
  logic [N-1:0]   s_axis_tready;
  logic [W-1:0]   m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic [1:0]     m_axis_tid;
  logic           m_axis_tlast;
  logic           busy;

  int checks = 0, failures = 0;

  // source side state (owned by the stimulus)
  int           seq[N];
  int           left[N];
  logic [N-1:0] hs_vec = '0;
  bit           rnd_on = 1'b0;
  int           mrdy_mode = 0;
  bit           mrdy_tog = 1'b0;

  // observation counters
  int   hs_cnt = 0, tlast_cnt = 0;
  int   grant_log[$];
  logic prev_busy = 1'b0;

  // reference model
  bit mdl_ok = 1'b0, m_burst = 1'b0;
  int m_hold = 0, m_last = N - 1, m_cur = 0, m_beats = 0, m_streak = 0;

  always #5 aclk = ~aclk;

  axis_fifo_arbiter #(
    .AXIS_TDATA_WIDTH(W), .NUM_PORTS(N), .BURST_LEN(BL),
    .FIFO_DEPTH(DEPTH), .IDLE_TIMEOUT(TO), .HOLD_CYCLES(HC)
  ) dut (
    .aclk(aclk), .areset(areset), .write_count(write_count),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tid(m_axis_tid), .m_axis_tlast(m_axis_tlast), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare DUT against the model mid-cycle, then advance the model over the next edge
  always @(negedge aclk) begin
    logic [N-1:0] e_rdy;
    logic         e_v;
    bit           room, found, hs;
    int           p;
    if (mdl_ok) begin
      e_v   = m_burst && s_axis_tvalid[m_cur];
      e_rdy = (m_burst && m_axis_tready) ? N'(1 << m_cur) : {N{1'b0}};
      chk("busy",   64'(busy),          64'(m_burst || m_hold > 0));
      chk("tvalid", 64'(m_axis_tvalid), 64'(e_v));
      chk("sready", 64'(s_axis_tready), 64'(e_rdy));
      chk("tid",    64'(m_axis_tid),    64'(m_cur));
      chk("tlast",  64'(m_axis_tlast),  64'(m_burst && m_beats == BL - 1));
      if (e_v) chk("tdata", 64'(m_axis_tdata), 64'({8'(m_cur), 24'(seq[m_cur])}));
    end
    hs_vec = s_axis_tvalid & s_axis_tready;
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      hs_cnt++;
      if (m_axis_tlast === 1'b1) tlast_cnt++;
    end
    if (busy === 1'b1 && prev_busy !== 1'b1) grant_log.push_back(int'(m_axis_tid));
    prev_busy = busy;
    if (areset) begin
      mdl_ok = 1'b1; m_burst = 1'b0; m_hold = 0; m_last = N - 1;
      m_cur = 0; m_beats = 0; m_streak = 0;
    end else if (mdl_ok) begin
      if (m_burst) begin
        hs = s_axis_tvalid[m_cur] && m_axis_tready;
        if (hs) begin m_beats++; m_streak = 0; end
        else if (!s_axis_tvalid[m_cur]) m_streak++;
        else m_streak = 0;
        if (m_beats == BL || m_streak == TO) begin
          m_burst = 1'b0; m_last = m_cur; m_hold = HC;
        end
      end else if (m_hold > 0) begin
        m_hold--;
      end else begin
        room  = (int'(write_count) <= DEPTH) && (DEPTH - int'(write_count) >= BL);
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          p = (m_last + k) % N;
          if (room && !found && s_axis_tvalid[p]) begin found = 1'b1; m_cur = p; end
        end
        if (found) begin m_burst = 1'b1; m_beats = 0; m_streak = 0; end
      end
    end
  end

  // One clock of stimulus: retire source beats, then drive new source/sink inputs
  task automatic step(input logic [N-1:0] mask);
    logic [N-1:0] v;
    @(posedge aclk); #1;
    for (int i = 0; i < N; i++) begin
      if (hs_vec[i]) begin
        seq[i]++;
        if (left[i] > 0) left[i]--;
      end
      v[i] = (left[i] > 0) && mask[i] && (!rnd_on || $urandom_range(0, 3) != 0);
      s_axis_tdata[i*W +: W] = {8'(i), 24'(seq[i])};
    end
    s_axis_tvalid = v;
    case (mrdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       begin mrdy_tog = !mrdy_tog; m_axis_tready = mrdy_tog; end
      default: m_axis_tready = ($urandom_range(0, 1) == 1);
    endcase
  endtask

  task automatic reset_dut();
    for (int i = 0; i < N; i++) left[i] = 0;
    areset = 1'b1;
    step('0);
    step('0);
    areset = 1'b0;
    grant_log.delete();
  endtask

  initial begin
    int h0, t0;
    int exp_order[5];
    logic [N-1:0] rmask;
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) begin seq[i] = 0; left[i] = 0; end
    areset = 1'b1; write_count = 16'd0; s_axis_tvalid = '0;
    s_axis_tdata = '0; m_axis_tready = 1'b1;

    // T1: port2 streams 40 beats -> 16, 16, 8 (timeout cut)
    reset_dut();
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_tid",   64'(m_axis_tid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    h0 = hs_cnt; t0 = tlast_cnt; left[2] = 40;
    repeat (75) step(4'hF);
    chk("t1_beats",  64'(hs_cnt - h0), 64'd40);
    chk("t1_tlasts", 64'(tlast_cnt - t0), 64'd2);
    chk("t1_nburst", 64'(grant_log.size()), 64'd3);
    foreach (grant_log[k]) chk("t1_gid", 64'(grant_log[k]), 64'd2);

    // T2: all ports continuously valid -> order 0,1,2,3,0
    reset_dut();
    for (int i = 0; i < N; i++) left[i] = 1000;
    repeat (90) step(4'hF);
    chk("t2_nburst", 64'(grant_log.size() >= 5), 64'd1);
    for (int k = 0; k < 5; k++)
      chk("t2_order", 64'((grant_log.size() > k) ? grant_log[k] : -1), 64'(exp_order[k]));

    // T3: room threshold at write_count 497 / 496
    reset_dut();
    write_count = 16'd497; left[1] = 20;
    repeat (10) step(4'hF);
    chk("t3_nogrant", 64'(grant_log.size()), 64'd0);
    write_count = 16'd496;
    repeat (2) step(4'hF);
    chk("t3_grant", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'd1);
    repeat (30) step(4'hF);
    write_count = 16'd0;

    // T4: sink stalls every other cycle
    reset_dut();
    h0 = hs_cnt; t0 = tlast_cnt; left[0] = 16; mrdy_mode = 1;
    repeat (45) step(4'hF);
    chk("t4_beats",  64'(hs_cnt - h0), 64'd16);
    chk("t4_tlasts", 64'(tlast_cnt - t0), 64'd1);
    mrdy_mode = 0;

    // T5: reset on beat 7 aborts the burst; port 0 wins afterwards
    reset_dut();
    left[0] = 100; left[1] = 100;
    repeat (8) step(4'hF);
    areset = 1'b1;
    step(4'hF);
    chk("t5_sready", 64'(s_axis_tready), 64'd0);
    chk("t5_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t5_busy",   64'(busy), 64'd0);
    areset = 1'b0; grant_log.delete();
    repeat (5) step(4'hF);
    chk("t5_first", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'd0);
    repeat (30) step(4'hF);

    // T6: 7 idle cycles tolerated, 8 cut the burst; pointer then at 3
    reset_dut();
    t0 = tlast_cnt; left[3] = 100;
    repeat (5) step(4'hF);
    repeat (7) step(4'h7);
    step(4'hF);
    chk("t6_kept_busy", 64'(busy), 64'd1);
    chk("t6_kept_tid",  64'(m_axis_tid), 64'd3);
    repeat (3) step(4'hF);
    repeat (8) step(4'h7);
    repeat (4) step(4'h0);
    chk("t6_cut_idle",  64'(busy), 64'd0);
    chk("t6_no_tlast",  64'(tlast_cnt - t0), 64'd0);
    left[0] = 5; grant_log.delete();
    repeat (3) step(4'h9);
    chk("t6_next", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'd0);
    repeat (20) step(4'h0);

    // Random phase: sources, sink, room and occasional resets all randomized
    reset_dut();
    rnd_on = 1'b1; mrdy_mode = 2;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (left[i] == 0 && $urandom_range(0, 7) == 0) left[i] = $urandom_range(1, 40);
      case ($urandom_range(0, 3))
        0:       write_count = 16'd0;
        1:       write_count = 16'($urandom_range(494, 498));
        2:       write_count = 16'($urandom_range(500, 530));
        default: write_count = 16'($urandom_range(0, 511));
      endcase
      areset = ($urandom_range(0, 399) == 0);
      rmask  = N'($urandom_range(0, 15));
      step(($urandom_range(0, 1) == 1) ? 4'hF : rmask);
    end
    areset = 1'b0;
    step('0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
